div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider for the EX stage, serving DIV and DIVU. EX hands it the operands already staged in the ID/EX register and holds the front of the pipeline stalled (ID/EX `en` low) until `ready_o` rises. It returns the remainder for HI and the quotient for LO. It uses one radix-2 restoring iteration per cycle.

## Interface
- No parameters; data width is fixed at 32 (RegBus).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start_i` in 1: divide request from EX; held high until EX sees `ready_o`.
- `annul_i` in 1: abort the operation in flight (flush or exception).
- `signed_div_i` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` in 32: dividend.
- `opdata2_i` in 32: divisor.
- `result_o` out 64: {remainder[63:32], quotient[31:0]}.
- `ready_o` out 1: result valid.

## Operation
- States: FREE, BYZERO, ON, END.
- Registers:
  - 65-bit working register `dividend` = {partial remainder[64:32], quotient bits[31:0]}.
  - 32-bit latched divisor.
  - 6-bit counter `cnt`.
  - Latched sign flags.
- FREE:
  - `start_i`=1, `annul_i`=0, divisor==0 -> BYZERO.
  - `start_i`=1, `annul_i`=0, divisor!=0 -> ON.
    - If signed, latch |opdata1| and |opdata2| (two's-complement negate when bit 31 is set).
    - Latch the sign flags: quotient negative = op1[31]^op2[31]; remainder negative = op1[31]. Both are 0 when unsigned.
    - `dividend` <= {33'b0, |op1|}; `cnt` <= 0.
  - Otherwise stay in FREE.
- BYZERO: unconditionally -> END with `dividend` result = 0.
- ON, `annul_i`=1 -> FREE; results discarded.
- ON, `annul_i`=0, each cycle:
  - Shift `dividend` left 1.
  - `trial` = shifted[64:32] - {1'b0, divisor} (33 bits).
  - If `trial` is non-negative (bit 32 == 0): upper part <= `trial`, bit0 <= 1.
  - Otherwise keep the shifted value; bit0 = 0.
  - `cnt` <= `cnt`+1.
  - The iteration performed while `cnt`==31 is the last. On that edge:
    - Quotient = low 32 bits, negated if the quotient-negative flag is set.
    - Remainder = bits[63:32], negated if the remainder-negative flag is set.
    - Both are loaded into the result register; state -> END.
- END:
  - `ready_o`=1; `result_o` = result register.
  - `start_i`=0 -> FREE: `ready_o` <= 0, `result_o` <= 0.
  - `start_i`=1 -> stay in END with the result held.
- `start_i` in BYZERO or ON is ignored; operands are not re-sampled during an operation.
- `annul_i` in FREE blocks a start in the same cycle.
- `annul_i` in END is ignored; EX drops `start_i` on flush.
- Signed corner case, 0x80000000 / 0xFFFFFFFF:
  - |op1| = 0x80000000 unsigned; the signs are equal.
  - Result: quotient 0x80000000, remainder 0 (no trap).

## Timing
- Reset, asynchronous on `rst` low:
  - state = FREE, `ready_o` = 0, `result_o` = 0, `cnt` = 0, `dividend` = 0.
  - Reset asserted mid-operation aborts it immediately. The first `start_i` after release begins a fresh divide.
- Normal latency:
  - Start is sampled at edge E0 (FREE -> ON).
  - Iterations run at edges E1..E32; END is entered at E32.
  - `ready_o` is high in the cycle after E32, 33 cycles after the start cycle.
- Divide by zero: FREE -> BYZERO at E0, -> END at E1; `ready_o` is high after E1.
- `ready_o` and `result_o` are registered outputs with no combinational path from any input.
- Back-to-back operations need at least one cycle with `start_i`=0 to return to FREE. The earliest next start is sampled in FREE, one cycle after `start_i` drops.
- `annul_i` sampled high during ON returns the unit to FREE on the next edge. `ready_o` never rises for that operation.

## Test plan
- DIVU 100 / 7, start held high:
  - `ready_o` rises exactly 33 cycles after the start cycle, with `result_o` = {32'd2, 32'd14}.
  - Drop start: `ready_o`=0 and `result_o`=0 next cycle.
- DIV -7 / 2 -> `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Divisor 0 (signed and unsigned) -> `ready_o` high 2 cycles after start, `result_o` = 0.
- Annul at `cnt`==10:
  - Unit is in FREE next cycle and `ready_o` stays 0 through the next 40 cycles.
  - A following DIVU 50/5 then yields {0, 10} at 33 cycles.
- Pull `rst` low asynchronously (between clock edges) mid-ON:
  - All outputs are 0 immediately.
  - After release, DIVU 9/3 completes normally with {0, 3}.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU in EX.
// Returns {remainder, quotient}; ready_o holds until start_i drops.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e      state_q;
  logic [64:0] dividend_q;
  logic [31:0] divisor_q;
  logic [5:0]  cnt_q;
  logic        quot_neg_q;
  logic        rem_neg_q;

  logic [31:0] abs_op1;
  logic [31:0] abs_op2;
  logic [64:0] shifted;
  logic [32:0] trial;
  logic [64:0] iter;
  logic [31:0] quot_fin;
  logic [31:0] rem_fin;

  always_comb begin
    abs_op1  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    abs_op2  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    shifted  = dividend_q << 1;
    trial    = shifted[64:32] - {1'b0, divisor_q};
    // A clear borrow bit means the divisor fits: keep the difference, emit a 1.
    iter     = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
    quot_fin = quot_neg_q ? (~iter[31:0] + 32'd1) : iter[31:0];
    rem_fin  = rem_neg_q ? (~iter[63:32] + 32'd1) : iter[63:32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFree;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      unique case (state_q)
        StFree: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state_q <= StByZero;
            end else begin
              state_q    <= StOn;
              dividend_q <= {33'b0, abs_op1};
              divisor_q  <= abs_op2;
              cnt_q      <= '0;
              quot_neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              rem_neg_q  <= signed_div_i & opdata1_i[31];
            end
          end
        end
        StByZero: begin
          state_q    <= StEnd;
          dividend_q <= '0;
          result_o   <= '0;
          ready_o    <= 1'b1;
        end
        StOn: begin
          if (annul_i) begin
            state_q <= StFree;
          end else begin
            dividend_q <= iter;
            cnt_q      <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_q  <= StEnd;
              result_o <= {rem_fin, quot_fin};
              ready_o  <= 1'b1;
            end
          end
        end
        StEnd: begin
          if (!start_i) begin
            state_q  <= StFree;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state_q <= StFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, annul and asynchronous reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad = 0;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  always #5 clk = ~clk;

  // Called at a negedge; raises start and waits (bounded) for ready_o.
  // lat is the number of cycles from the start cycle to ready_o, 0 on timeout.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = n;
        break;
      end
    end
    res = result_o;
  endtask

  task automatic test_reset;
    #3;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    int lat;
    logic [63:0] res;
    run_div(1'b0, 32'd100, 32'd7, lat, res);
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL divu_latency: got %0d cycles, want 33", lat);
    end
    total++;
    if (res !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL divu_100_7: got %h, want %h", res, {32'd2, 32'd14});
    end
    repeat (2) @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL end_hold: ready=%b result=%h, want ready=1 result=%h",
               ready_o, result_o, {32'd2, 32'd14});
    end
    start_i = 1'b0;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL drop_start: ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
    end
  endtask

  task automatic test_results;
    logic        sg [6];
    logic [31:0] a  [6];
    logic [31:0] b  [6];
    logic [63:0] ex [6];
    int lat;
    logic [63:0] res;
    sg[0] = 1; a[0] = 32'hFFFF_FFF9; b[0] = 32'd2;         ex[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    sg[1] = 1; a[1] = 32'd7;         b[1] = 32'hFFFF_FFFE; ex[1] = {32'h0000_0001, 32'hFFFF_FFFD};
    sg[2] = 1; a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF; ex[2] = {32'h0000_0000, 32'h8000_0000};
    sg[3] = 0; a[3] = 32'hFFFF_FFFF; b[3] = 32'd1;         ex[3] = {32'h0000_0000, 32'hFFFF_FFFF};
    sg[4] = 0; a[4] = 32'hFFFF_FFFF; b[4] = 32'h10;        ex[4] = {32'h0000_000F, 32'h0FFF_FFFF};
    sg[5] = 1; a[5] = 32'hFFFF_FF9C; b[5] = 32'd7;         ex[5] = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
    for (int i = 0; i < 6; i++) begin
      run_div(sg[i], a[i], b[i], lat, res);
      total++;
      if (lat !== 33 || res !== ex[i]) begin
        bad++;
        $display("FAIL result_%0d: lat=%0d result=%h, want lat=33 result=%h", i, lat, res, ex[i]);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero;
    int lat;
    logic [63:0] res;
    for (int i = 0; i < 2; i++) begin
      run_div(i == 0, (i == 0) ? 32'hFFFF_FFFB : 32'd7, 32'd0, lat, res);
      total++;
      if (lat !== 2 || res !== 64'd0) begin
        bad++;
        $display("FAIL div_zero_%0d: lat=%0d result=%h, want lat=2 result=0", i, lat, res);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_annul;
    int lat;
    int seen;
    logic [63:0] res;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(negedge clk);  // cnt == 10 in this cycle
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (ready_o !== 1'b0) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL annul_no_ready: ready high %0d cycles, want 0", seen);
    end
    run_div(1'b0, 32'd50, 32'd5, lat, res);
    total++;
    if (lat !== 33 || res !== {32'd0, 32'd10}) begin
      bad++;
      $display("FAIL after_annul: lat=%0d result=%h, want lat=33 result=%h",
               lat, res, {32'd0, 32'd10});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_annul_blocks_start;
    int lat;
    logic [63:0] res;
    opdata1_i = 32'd21;
    opdata2_i = 32'd4;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    run_div(1'b0, 32'd21, 32'd4, lat, res);
    total++;
    if (lat !== 33 || res !== {32'd1, 32'd5}) begin
      bad++;
      $display("FAIL annul_blocks_start: lat=%0d result=%h, want lat=33 result=%h",
               lat, res, {32'd1, 32'd5});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [63:0] res;
    run_div(1'b0, 32'd77, 32'd10, lat, res);
    start_i = 1'b0;
    @(negedge clk);
    run_div(1'b1, 32'hFFFF_FFB3, 32'd10, lat, res);  // -77 / 10
    total++;
    if (lat !== 33 || res !== {32'hFFFF_FFF9, 32'hFFFF_FFF9}) begin
      bad++;
      $display("FAIL back_to_back: lat=%0d result=%h, want lat=33 result=%h",
               lat, res, {32'hFFFF_FFF9, 32'hFFFF_FFF9});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int lat;
    logic [63:0] res;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd500;
    opdata2_i    = 32'd9;
    start_i      = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid_on: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div(1'b0, 32'd9, 32'd3, lat, res);
    total++;
    if (lat !== 33 || res !== {32'd0, 32'd3}) begin
      bad++;
      $display("FAIL after_reset: lat=%0d result=%h, want lat=33 result=%h",
               lat, res, {32'd0, 32'd3});
    end
    // Reset while a result is being held must clear the outputs at once.
    #2 rst = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_in_end: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_results();
    test_div_by_zero();
    test_annul();
    test_annul_blocks_start();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
